// File: rtl/ad9833_pkg.sv
// Shared definitions for the AD9833 sweep sequencer: FSM state encoding,
// serializer byte-enable codes, word widths and the datain packing helper.
// Ports: none (package).
package ad9833_pkg;

  localparam int FREQ_W = 28;
  localparam int CTRL_W = 16;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_FREQ = 4'b0001;
  localparam logic [3:0] BE_CTRL = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CTRL,
    S_LOAD_FREQ,
    S_ASSERT_GO,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DWELL,
    S_FINISH
  } state_t;

  // Tuning words travel right-aligned in the 32-bit serializer data bus.
  function automatic logic [31:0] pack_freq(input logic [FREQ_W-1:0] f);
    return {{(32-FREQ_W){1'b0}}, f};
  endfunction

  function automatic logic [31:0] pack_ctrl(input logic [CTRL_W-1:0] c);
    return {{(32-CTRL_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/ad9833_dwell_timer.sv
// Load/count/expire down-counter, used both for the post-send dwell and for
// the go-to-send_complete timeout.
// Ports: clk, resetn (sync, active-low), load + load_val, en (count), expired (count==0).
module ad9833_dwell_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ad9833_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding the AD9833 serializer: one control
// word per sweep, then one 28-bit tuning word per point, each followed by a
// programmable dwell. go is held until good_to_reset_go; a missing
// send_complete after TIMEOUT_CLKS raises the sticky err_timeout.
// Ports: clk/resetn (sync, active-low); start/abort pulses; cfg_* sweep setup
// (latched on start); go/byteenable/datain to the serializer,
// good_to_reset_go/send_complete back; busy/done/err_timeout/step_idx status.
// Build option: AD9833_SWEEP_PINGPONG_EN -- after num_steps increments the
// step is negated and the sweep walks back to start_freq (2*num_steps+1 points).
module ad9833_sweep_ctrl
  import ad9833_pkg::*;
#(
  parameter int STEPS_W      = 16,
  parameter int DWELL_W      = 32,
  parameter int TIMEOUT_CLKS = 65535
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [CTRL_W-1:0]  cfg_ctrl,
  input  logic [FREQ_W-1:0]  cfg_start_freq,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [STEPS_W-1:0] cfg_num_steps,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic               go,
  output logic [3:0]         byteenable,
  output logic [31:0]        datain,
  input  logic               good_to_reset_go,
  input  logic               send_complete,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic [STEPS_W-1:0] step_idx
);

  localparam logic [31:0] TO_LOAD = 32'(TIMEOUT_CLKS - 1);

  state_t             state;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [FREQ_W-1:0]  step_q;
  logic [STEPS_W-1:0] nsteps_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [FREQ_W-1:0]  freq;
  // One extra bit so the ping-pong point index (up to 2*num_steps) fits.
  logic [STEPS_W:0]   idx;
  logic               abort_pending;

  logic [STEPS_W:0]   last_idx;
  logic [FREQ_W-1:0]  step_sel;
  logic [FREQ_W-1:0]  next_freq;
  logic               is_last;
  logic               dwell_expired;
  logic               to_expired;

`ifdef AD9833_SWEEP_PINGPONG_EN
  assign last_idx = {nsteps_q, 1'b0};
  // Increments beyond the first num_steps walk back down.
  assign step_sel = (idx >= {1'b0, nsteps_q}) ? (~step_q + 1'b1) : step_q;
`else
  assign last_idx = {1'b0, nsteps_q};
  assign step_sel = step_q;
`endif

  assign is_last   = (idx == last_idx);
  // Modulo 2^FREQ_W on purpose: tuning words wrap like DDS phase.
  assign next_freq = freq + step_sel;
  assign step_idx  = idx[STEPS_W-1:0];

  ad9833_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .resetn   (resetn),
    .load     ((state == S_WAIT_DONE) && send_complete),
    .load_val (dwell_q),
    .en       (state == S_DWELL),
    .expired  (dwell_expired)
  );

  ad9833_dwell_timer #(.W(32)) u_timeout (
    .clk      (clk),
    .resetn   (resetn),
    .load     (state == S_LOAD_FREQ),
    .load_val (TO_LOAD),
    .en       ((state == S_WAIT_ACK) || (state == S_WAIT_DONE)),
    .expired  (to_expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      go            <= 1'b0;
      byteenable    <= BE_NONE;
      datain        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      idx           <= '0;
      freq          <= '0;
      ctrl_q        <= '0;
      step_q        <= '0;
      nsteps_q      <= '0;
      dwell_q       <= '0;
      abort_pending <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort never cuts a transfer; it only ends the sweep at the next dwell exit.
      if (abort && (state != S_IDLE)) abort_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            ctrl_q        <= cfg_ctrl;
            step_q        <= cfg_step;
            nsteps_q      <= cfg_num_steps;
            dwell_q       <= cfg_dwell;
            freq          <= cfg_start_freq;
            idx           <= '0;
            busy          <= 1'b1;
            err_timeout   <= 1'b0;
            abort_pending <= 1'b0;
            byteenable    <= BE_CTRL;
            datain        <= pack_ctrl(cfg_ctrl);
            state         <= S_LOAD_CTRL;
          end
        end
        S_LOAD_CTRL: begin
          byteenable <= BE_FREQ;
          datain     <= pack_freq(freq);
          state      <= S_LOAD_FREQ;
        end
        S_LOAD_FREQ: begin
          byteenable <= BE_NONE;
          go         <= 1'b1;
          state      <= S_ASSERT_GO;
        end
        S_ASSERT_GO: begin
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (to_expired) begin
            err_timeout <= 1'b1;
            go          <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_FINISH;
          end else if (good_to_reset_go) begin
            go    <= 1'b0;
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (send_complete) begin
            state <= S_DWELL;
          end else if (to_expired) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_FINISH;
          end
        end
        S_DWELL: begin
          if (dwell_expired) begin
            if (is_last || abort_pending) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FINISH;
            end else begin
              freq       <= next_freq;
              idx        <= idx + 1'b1;
              byteenable <= BE_FREQ;
              datain     <= pack_freq(next_freq);
              state      <= S_LOAD_FREQ;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9833_sweep_ctrl.sv
// Self-checking bench for ad9833_sweep_ctrl with a behavioural serializer
// (CLKS_PER_BIT=4, one 16-bit frame per go) and a closed-form sweep model.
// Honors AD9833_SWEEP_PINGPONG_EN in the reference model.
module tb_ad9833_sweep_ctrl;

  localparam int CLKS_PER_BIT = 4;
  localparam int FRAME_CLKS   = 16 * CLKS_PER_BIT;
  localparam int TO_CLKS      = 100;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_ctrl = '0;
  logic [27:0] cfg_start_freq = '0;
  logic [27:0] cfg_step = '0;
  logic [15:0] cfg_num_steps = '0;
  logic [31:0] cfg_dwell = '0;
  logic        go;
  logic [3:0]  byteenable;
  logic [31:0] datain;
  logic        good_to_reset_go;
  logic        send_complete;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic [15:0] step_idx;

  always #5 clk = ~clk;

  ad9833_sweep_ctrl #(.STEPS_W(16), .DWELL_W(32), .TIMEOUT_CLKS(TO_CLKS)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .start            (start),
    .abort            (abort),
    .cfg_ctrl         (cfg_ctrl),
    .cfg_start_freq   (cfg_start_freq),
    .cfg_step         (cfg_step),
    .cfg_num_steps    (cfg_num_steps),
    .cfg_dwell        (cfg_dwell),
    .go               (go),
    .byteenable       (byteenable),
    .datain           (datain),
    .good_to_reset_go (good_to_reset_go),
    .send_complete    (send_complete),
    .busy             (busy),
    .done             (done),
    .err_timeout      (err_timeout),
    .step_idx         (step_idx)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- serializer model ----------------
  bit         no_complete = 1'b0;
  logic       ser_active;
  logic [7:0] ser_cnt;

  always @(posedge clk) begin
    if (!resetn) begin
      ser_active       <= 1'b0;
      ser_cnt          <= '0;
      good_to_reset_go <= 1'b0;
      send_complete    <= 1'b0;
    end else begin
      send_complete    <= 1'b0;
      good_to_reset_go <= ser_active && go;
      if (go && !ser_active) begin
        ser_active <= 1'b1;
        ser_cnt    <= '0;
      end else if (ser_active) begin
        ser_cnt <= ser_cnt + 1'b1;
        if ((ser_cnt == 8'(FRAME_CLKS - 1)) && !no_complete) begin
          send_complete <= 1'b1;
          ser_active    <= 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] sent[$];
  logic [31:0] cur_word = '0;
  logic [31:0] ctrl_seen = '0;
  int ctrl_cnt = 0, done_cnt = 0, be_viol = 0;
  int cyc = 0, go_rise_cyc = 0, err_rise_cyc = 0;
  logic go_q = 1'b0, err_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (resetn) begin
      if (byteenable == 4'b0010) begin
        ctrl_cnt++;
        ctrl_seen = datain;
      end
      if (byteenable == 4'b0001) cur_word = datain;
      if (go && !go_q) begin
        sent.push_back(cur_word);
        go_rise_cyc = cyc;
      end
      if (err_timeout && !err_q) err_rise_cyc = cyc;
      if (done) done_cnt++;
      if ((byteenable != 4'b0000) && ser_active) be_viol++;
    end
    go_q  = go;
    err_q = err_timeout;
  end

  // ---------------- reference model ----------------
  function automatic int model_points(input int n);
`ifdef AD9833_SWEEP_PINGPONG_EN
    return 2 * n + 1;
`else
    return n + 1;
`endif
  endfunction

  // Point i sits k steps from start_freq; everything taken modulo 2^28.
  function automatic logic [27:0] model_freq(input logic [27:0] sf, input logic [27:0] st,
                                             input int n, input int i);
    longint k;
`ifdef AD9833_SWEEP_PINGPONG_EN
    k = (i <= n) ? i : (2 * n - i);
`else
    k = i;
    if (n < 0) k = 0;
`endif
    return 28'((longint'(sf) + k * longint'(st)) & 64'h0FFF_FFFF);
  endfunction

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == 0) check("done_wait_expired", 0, 1);
  endtask

  task automatic run_sweep(input string nm, input logic [27:0] sf, input logic [27:0] st,
                           input int n, input logic [31:0] dw, input int abort_after,
                           input bit start_abort, input bit no_comp);
    logic [15:0] ctrl;
    int npts, k;
    ctrl = 16'($urandom);
    sent.delete();
    ctrl_cnt = 0; done_cnt = 0; be_viol = 0;
    no_complete = no_comp;
    cfg_ctrl = ctrl; cfg_start_freq = sf; cfg_step = st;
    cfg_num_steps = 16'(n); cfg_dwell = dw;
    @(negedge clk);
    start = 1'b1; abort = start_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    // A running sweep must ignore later cfg changes.
    cfg_ctrl = 16'($urandom); cfg_start_freq = 28'($urandom); cfg_step = 28'($urandom);
    cfg_num_steps = 16'($urandom); cfg_dwell = $urandom;
    if (abort_after < 0 && $urandom_range(1, 0) == 1) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (abort_after >= 0) begin
      k = 0;
      while (sent.size() == 0 && k < 50) begin
        @(negedge clk);
        k++;
      end
      repeat (abort_after) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    wait_done(6000);
    repeat (3) @(negedge clk);

    npts = (abort_after >= 0 || no_comp) ? 1 : model_points(n);
    check({nm, "_npoints"}, 64'(sent.size()), 64'(npts));
    for (int i = 0; i < npts && i < sent.size(); i++)
      check($sformatf("%s_freq%0d", nm, i), 64'(sent[i]), {36'b0, model_freq(sf, st, n, i)});
    check({nm, "_ctrl_cnt"}, 64'(ctrl_cnt), 64'd1);
    check({nm, "_ctrl_word"}, 64'(ctrl_seen), {48'b0, ctrl});
    check({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({nm, "_busy"}, 64'(busy), 64'd0);
    check({nm, "_go"}, 64'(go), 64'd0);
    check({nm, "_err"}, 64'(err_timeout), 64'(no_comp));
    check({nm, "_step_idx"}, 64'(step_idx), 64'(npts - 1));
    check({nm, "_be_overlap"}, 64'(be_viol), 64'd0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_go", 64'(go), 0);
    check("rst_be", 64'(byteenable), 0);
    check("rst_datain", 64'(datain), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err_timeout), 0);
    check("rst_step_idx", 64'(step_idx), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Abort while idle must not stick to the next sweep.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 0);

    run_sweep("t1", 28'h100, 28'h10, 3, 32'd5, -1, 1'b0, 1'b0);
`ifndef AD9833_SWEEP_PINGPONG_EN
    check("t1_last_freq", 64'(sent[3]), 64'h130);
`endif
    run_sweep("t2", 28'hFFFFFF0, 28'h20, 1, 32'd2, -1, 1'b0, 1'b0);
    check("t2_wrap_freq", 64'(sent[1]), 64'h0000010);
    run_sweep("t3_abort", 28'h1234, 28'h40, 5, 32'd3, 2, 1'b0, 1'b0);
    run_sweep("start_abort", 28'h777, 28'hFFFFFF8, 2, 32'd0, -1, 1'b1, 1'b0);
    run_sweep("n0", 28'hABCDEF, 28'h5, 0, 32'd0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++)
      run_sweep($sformatf("rnd%0d", r), 28'($urandom), 28'($urandom),
                int'($urandom_range(4, 0)), 32'($urandom_range(6, 0)), -1, 1'b0, 1'b0);

`ifdef AD9833_SWEEP_PINGPONG_EN
    run_sweep("t5_pp", 28'h40, 28'h8, 2, 32'd1, -1, 1'b0, 1'b0);
    check("t5_mid_freq", 64'(sent[2]), 64'h50);
    check("t5_end_freq", 64'(sent[4]), 64'h40);
`endif

    // Serializer never completes: timeout about TO_CLKS after go.
    run_sweep("t4_to", 28'h300, 28'h1, 3, 32'd0, -1, 1'b0, 1'b1);
    k = err_rise_cyc - go_rise_cyc;
    check("t4_to_latency_window", 64'(k >= TO_CLKS - 1 && k <= TO_CLKS + 3), 1);
    repeat (10) @(negedge clk);
    check("t4_err_sticky", 64'(err_timeout), 1);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    no_complete = 1'b0;
    @(negedge clk);

    // Reset in the middle of WAIT_DONE.
    sent.delete();
    cfg_start_freq = 28'h500; cfg_step = 28'h1; cfg_num_steps = 16'd4; cfg_dwell = 32'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(sent.size() > 0 && !go) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t6_reached_wait_done", 64'(sent.size() > 0 && !go), 1);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_go", 64'(go), 0);
    check("t6_rst_busy", 64'(busy), 0);
    check("t6_rst_be", 64'(byteenable), 0);
    check("t6_rst_step_idx", 64'(step_idx), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_sweep("t6_after", 28'h900, 28'h3, 2, 32'd1, -1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit got=timeout exp=finish");
    $fatal(1, "time limit");
  end

endmodule
